// File: rtl/prog_timer_if.sv
// Purpose: control/status bundle between a timer user (master) and prog_timer (slave).
// Signals:
//   load        master->slave  load new_value and restart timing
//   new_value   master->slave  value to load (WIDTH bits)
//   auto_reload master->slave  1 = reload on expiry, 0 = one-shot
//   pause       master->slave  level; 1 freezes prescaler and value
//   value       slave->master  current count (registered)
//   zero        slave->master  value == 0
//   expired     slave->master  one-cycle pulse when value leaves 1
//   running     slave->master  timer is counting
interface prog_timer_if #(
  parameter int unsigned WIDTH = 6
);
  logic             load;
  logic [WIDTH-1:0] new_value;
  logic             auto_reload;
  logic             pause;
  logic [WIDTH-1:0] value;
  logic             zero;
  logic             expired;
  logic             running;

  modport master (
    output load, new_value, auto_reload, pause,
    input  value, zero, expired, running
  );

  modport slave (
    input  load, new_value, auto_reload, pause,
    output value, zero, expired, running
  );
endinterface

// File: rtl/prog_timer.sv
// Purpose: loadable down-counting timer; an internal prescaler produces one
// decrement tick every PRESCALE clock cycles while running and not paused.
// Supports one-shot and auto-reload, and pulses expired for one cycle when
// the count leaves 1.
// Ports:
//   ck     system clock, rising edge
//   reset  synchronous active-low reset
//   bus    prog_timer_if.slave: load/new_value/auto_reload/pause in,
//          value/zero/expired/running out
module prog_timer #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned PRESCALE = 10_000_000,
  parameter int unsigned PS_WIDTH = 24
) (
  input  logic         ck,
  input  logic         reset,
  prog_timer_if.slave  bus
);

  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q,   state_d;
  logic [WIDTH-1:0]    value_q,   value_d;
  logic [WIDTH-1:0]    reload_q,  reload_d;
  logic [PS_WIDTH-1:0] ps_q,      ps_d;
  logic                expired_q, expired_d;
  logic                tick_c;

  // State register with synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!reset) begin
      state_q   <= IDLE;
      value_q   <= '0;
      reload_q  <= '0;
      ps_q      <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      ps_q      <= ps_d;
      expired_q <= expired_d;
    end
  end

  // Tick only fires when the prescaler would actually advance this edge.
  assign tick_c = (state_q == RUN) && !bus.load && !bus.pause && (ps_q == PS_LAST);

  // Next-state logic: load > pause > tick.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    reload_d  = reload_q;
    ps_d      = ps_q;
    expired_d = 1'b0;

    if (bus.load) begin
      value_d  = bus.new_value;
      reload_d = bus.new_value;
      ps_d     = '0;
      state_d  = (bus.new_value != '0) ? RUN : IDLE;
    end else if (bus.pause) begin
      // freeze everything
    end else begin
      case (state_q)
        IDLE: begin
          ps_d    = '0;
          value_d = '0;
        end
        RUN: begin
          if (tick_c) begin
            ps_d = '0;
            if (value_q > WIDTH'(1)) begin
              value_d = value_q - WIDTH'(1);
            end else begin
              // value_q is 1 here: RUN is never entered with a zero count
              expired_d = 1'b1;
              if (bus.auto_reload) begin
                value_d = reload_q;
              end else begin
                value_d = '0;
                state_d = IDLE;
              end
            end
          end else begin
            ps_d = ps_q + PS_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.value   = value_q;
  assign bus.zero    = (value_q == '0);
  assign bus.expired = expired_q;
  assign bus.running = (state_q == RUN);

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: a driver applies per-cycle stimulus and
// pushes the reference model's expected post-edge outputs; a monitor pops
// and compares one snapshot after every rising edge.
module tb_prog_timer;

  localparam int unsigned WIDTH    = 6;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PS_WIDTH = 4;

  typedef struct {
    int value;
    int zero;
    int expired;
    int running;
  } exp_t;

  logic ck;
  logic reset;

  prog_timer_if #(.WIDTH(WIDTH)) bus ();

  prog_timer #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE),
    .PS_WIDTH(PS_WIDTH)
  ) dut (
    .ck   (ck),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;

  // Reference model: count, reload value, running flag and the number of
  // active (running, unpaused, not loading) edges still needed for a decrement.
  int m_val    = 0;
  int m_reload = 0;
  int m_run    = 0;
  int m_left   = PRESCALE;
  int m_exp    = 0;
  int cur_ar   = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cycle, act, req);
    end
  endtask

  // One clock: drive inputs, advance model, queue expectation, wait an edge.
  task automatic step(input int rst_n, input int ld, input int nv, input int ar, input int pa);
    exp_t e;
    reset           = rst_n[0];
    bus.load        = ld[0];
    bus.new_value   = WIDTH'(nv);
    bus.auto_reload = ar[0];
    bus.pause       = pa[0];
    m_exp = 0;
    if (rst_n == 0) begin
      m_val = 0; m_reload = 0; m_run = 0; m_left = PRESCALE;
    end else if (ld != 0) begin
      m_val = nv; m_reload = nv; m_run = (nv != 0); m_left = PRESCALE;
    end else if (pa == 0 && m_run != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_left = PRESCALE;
        if (m_val > 1) begin
          m_val--;
        end else begin
          m_exp = 1;
          if (ar != 0) m_val = m_reload;
          else begin
            m_val = 0;
            m_run = 0;
          end
        end
      end
    end
    e.value   = m_val;
    e.zero    = (m_val == 0);
    e.expired = m_exp;
    e.running = m_run;
    exp_q.push_back(e);
    @(negedge ck);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, cur_ar, 0);
  endtask

  task automatic do_load(input int nv);
    step(1, 1, nv, cur_ar, 0);
  endtask

  // Monitor: compare one expected snapshot after each rising edge.
  always @(posedge ck) begin
    exp_t e;
    #1;
    cycle++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("value",   int'(bus.value),   e.value);
      chk("zero",    int'(bus.zero),    e.zero);
      chk("expired", int'(bus.expired), e.expired);
      chk("running", int'(bus.running), e.running);
    end
  end

  initial begin
    int r;
    int nv;
    // Reset dominates load and pause.
    step(0, 1, 5, 0, 1);
    step(0, 1, 5, 0, 1);
    idle(3);

    // One-shot: load 3, expire at e12, stay idle.
    cur_ar = 0;
    do_load(3);
    idle(40);

    // Auto-reload: load 2.
    cur_ar = 1;
    do_load(2);
    idle(17);

    // Pause on e2..e11.
    cur_ar = 0;
    do_load(3);
    idle(1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1);
    idle(13);

    // Reload mid-run at e6 while value is 2.
    do_load(3);
    idle(5);
    do_load(5);
    idle(6);

    // Zero load stops the timer without expiry.
    do_load(0);
    idle(3);

    // Reset mid-run at e9.
    do_load(5);
    idle(8);
    step(0, 0, 0, 0, 0);
    idle(3);

    // Load on the edge a value==1 tick would fire.
    do_load(1);
    idle(3);
    do_load(4);
    idle(10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cur_ar = 1 - cur_ar;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) nv = int'($urandom_range(0, 63));
      else nv = int'($urandom_range(0, 4));
      if (r == 0)       step(0, int'($urandom_range(0, 1)), nv, cur_ar, int'($urandom_range(0, 1)));
      else if (r < 6)   step(1, 1, nv, cur_ar, int'($urandom_range(0, 1)));
      else if (r < 24)  step(1, 0, nv, cur_ar, 1);
      else              step(1, 0, nv, cur_ar, 0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge ck);
    chk("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
